// File: rtl/func_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : func_arbiter_if
//  Description : Start/busy handshake bus between the arbiter and the shared
//                func unit (operands out, result back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface func_arbiter_if #(
    parameter int DW = 8,
    parameter int RW = 24
);
    logic          f_start;
    logic [DW-1:0] f_a;
    logic [DW-1:0] f_b;
    logic          f_busy;
    logic [RW-1:0] f_y;

    // Arbiter side: issues start and operands, observes busy and result
    modport master (
        output f_start,
        output f_a,
        output f_b,
        input  f_busy,
        input  f_y
    );

    // func side: consumes start and operands, returns busy and result
    modport slave (
        input  f_start,
        input  f_a,
        input  f_b,
        output f_busy,
        output f_y
    );
endinterface
`default_nettype wire

// File: rtl/func_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : func_arbiter
//  Description : Two-requester round-robin arbiter and sequencer for the
//                shared func unit. Latches the winner's operands, runs one
//                start/busy computation, captures y into result and pulses
//                the winner's done for one cycle.
//                Optional watchdog: define FUNC_ARB_TIMEOUT_EN to build a
//                cycle counter that aborts a stuck computation after TIMEOUT
//                cycles (result = all ones, sticky err, done still pulsed).
//  Revision    : 1.0 - initial release
// ============================================================================
module func_arbiter #(
    parameter int DW = 8,
    parameter int RW = 24
`ifdef FUNC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,      // synchronous, active-low
    input  wire logic          req0,
    input  wire logic          req1,
    input  wire logic [DW-1:0] a0,
    input  wire logic [DW-1:0] b0,
    input  wire logic [DW-1:0] a1,
    input  wire logic [DW-1:0] b1,
    output logic               done0,
    output logic               done1,
    output logic [RW-1:0]      result,
    output logic               err,
    func_arbiter_if.master     fbus
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ISSUE     = 3'd1;
    localparam logic [2:0] c_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_DELIVER   = 3'd4;

    logic [2:0] r_state;
    logic       r_owner;   // requester currently being served
    logic       r_last;    // requester served most recently (tie-break)
    logic       w_pick;    // winner if a grant happens this cycle
    logic       w_waiting; // in either busy-wait state
    logic       w_tmo;     // watchdog expired

    // Requester 1 wins when alone, or on a tie when requester 0 won last
    assign w_pick    = req1 & (~req0 | ~r_last);
    assign w_waiting = (r_state == c_WAIT_BUSY) || (r_state == c_WAIT_DONE);

`ifdef FUNC_ARB_TIMEOUT_EN
    localparam int             c_CW  = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMO = c_CW'(TIMEOUT);

    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    assign w_tmo = w_waiting && (r_cnt == c_TMO);
    assign err   = r_err;

    // Watchdog: count wait cycles, restart whenever the FSM leaves the waits
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_waiting)
                r_cnt <= '0;
            else if (!w_tmo)
                r_cnt <= r_cnt + 1'b1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    // Main sequencer: arbitrate, issue, wait for busy rise/fall, deliver
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            fbus.f_start <= 1'b0;
            fbus.f_a     <= '0;
            fbus.f_b     <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            result       <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req0 || req1) begin
                        r_owner      <= w_pick;
                        fbus.f_a     <= w_pick ? a1 : a0;
                        fbus.f_b     <= w_pick ? b1 : b0;
                        fbus.f_start <= 1'b1;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // busy seen here may be stale from a previous job
                    r_state <= c_WAIT_BUSY;
                end
                c_WAIT_BUSY: begin
                    if (w_tmo) begin
                        fbus.f_start <= 1'b0;
                        result       <= '1;
                        r_last       <= r_owner;
                        done0        <= ~r_owner;
                        done1        <= r_owner;
                        r_state      <= c_DELIVER;
                    end else if (fbus.f_busy) begin
                        fbus.f_start <= 1'b0;
                        r_state      <= c_WAIT_DONE;
                    end
                end
                c_WAIT_DONE: begin
                    if (!fbus.f_busy) begin
                        result  <= fbus.f_y;
                        r_last  <= r_owner;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                        r_state <= c_DELIVER;
                    end else if (w_tmo) begin
                        result  <= '1;
                        r_last  <= r_owner;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                        r_state <= c_DELIVER;
                    end
                end
                c_DELIVER: begin
                    // done is high during this cycle; always pass through IDLE
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
